cp0_intc_timer: RTL and testbench
=================================

// Module: cp0_intc_timer
// PURPOSE
//  Parametrised coprocessor 0 for the pipelined MIPS core. Successor to the fixed
//  6-line CP0: configurable interrupt line count, per-line edge/level latching,
//  a Count/Compare timer interrupt, BadVAddr, and nested-exception EPC rules.
//  Sits beside the M stage; int_req redirects fetch to the handler.
// PARAMETERS
//  N_HWINT    5             hardware interrupt lines, 1..5, mapped to IP/IM bits [10 +: N_HWINT]
//  EDGE_MASK  {N_HWINT{0}}  per-line latching mode: bit=1 edge-latched, bit=0 level
//  PRID       32'h1737_3552 value read from PRId (reg 15)
// PORTS
//  clk            in   1        clock
//  reset          in   1        asynchronous, active-high reset
//  rd_addr        in   5        mfc0 register address
//  rd_data        out  32       mfc0 read data, combinational
//  we             in   1        mtc0 write enable
//  wr_addr        in   5        mtc0 register address
//  wr_data        in   32       mtc0 write data
//  pc             in   32       PC of the M-stage instruction
//  in_delay_slot  in   1        M-stage instruction is in a branch/jump delay slot
//  exc_valid      in   1        synchronous exception present in M stage
//  exc_code       in   5        ExcCode for exc_valid
//  bad_vaddr      in   32       faulting address (AdEL=4 / AdES=5)
//  hwint          in   N_HWINT  external interrupt lines
//  eret           in   1        eret in M stage
//  int_req        out  1        take exception/interrupt this cycle
//  epc            out  32       EPC register value
// BEHAVIOUR
//  Registers: 8 BadVAddr(RO), 9 Count, 11 Compare, 12 SR{IM[15:10],EXL[1],IE[0]},
//   13 Cause{BD[31],TI[30],IP[15:10],ExcCode[6:2]}, 14 EPC, 15 PRId(RO). Other addresses read 0.
//  Reset: every register, the edge-detect samples, and TI clear to 0; int_req=0, epc=0, rd_data=0 for
//   the mapped registers except PRId.
//  IP[10+i]: level line = hwint[i] registered each cycle; edge line set on 0->1 of the registered
//   sample, held until an mtc0 Cause write with bit 10+i = 0. IP[15] = TI. IP bits not in use read 0.
//  Timer: Count +1 every cycle, wrapping 0xFFFF_FFFF->0. TI sets when the incremented value equals
//   Compare. An mtc0 write to Compare clears TI. An mtc0 write to Count replaces that cycle's increment.
//  int_req = exc_valid | (IE & ~EXL & |(IP & IM)), combinational. Exceptions are taken even when EXL=1.
//  Take (posedge where int_req=1):
//   - EXL<=1.
//   - ExcCode<= exc_valid ? exc_code : 0 (interrupt).
//   - If EXL was 0: BD<=in_delay_slot; EPC<={pc[31:2],2'b0} - (in_delay_slot ? 4 : 0).
//     If EXL was 1: BD and EPC are held.
//   - BadVAddr<=bad_vaddr when exc_code is 4 or 5.
//  eret: EXL<=0. A take in the same cycle wins and the eret is dropped.
//  mtc0:
//   - SR gets wr_data[15:10],[1:0]; EPC gets {wr_data[31:2],2'b0}; Cause writes only clear edge IP bits.
//   - A take in the same cycle overrides the fields the take writes. Other mtc0 targets still update.
//  rd_data shows pre-edge values; a same-cycle write is not bypassed.
//  Reset asserted mid-handler: immediate clear, with no pending state kept. A line held high through reset
//   latches (edge mode) on the first edge after release, because the stored sample resets to 0.
// STRUCTURE
//  Package cp0_pkg: register address localparams (CP0_SR=12...), ExcCode constants (INT=0, ADEL=4,
//   ADES=5, RI=10, OV=12), SR/Cause bit-position constants.
//  Sub-module cp0_timer: Count/Compare/TI, wrap, write-priority logic. The register file, edge latch
//   and take logic stay in the top.
// TESTING
//  1 reset; mtc0 SR=0x0000_0401; pulse hwint[0] (level) -> int_req=1 that cycle; EPC=pc; ExcCode=0; EXL=1.
//  2 exc_valid, exc_code=4, bad_vaddr=0x0000_3001, in_delay_slot=1, pc=0x3008 -> EPC=0x3004; BD=1;
//    BadVAddr=0x3001.
//  3 EXL=1, then exc_valid code 10 -> ExcCode=10; EPC unchanged; then eret -> EXL=0.
//  4 edge line (EDGE_MASK=1) 1-cycle pulse with IE=0 -> IP[10] stays 1; mtc0 Cause=0 -> IP[10]=0.
//  5 Count=0xFFFF_FFFE, Compare=0 -> TI=1 after 2 cycles (wrap); mtc0 Compare -> TI=0.
//  6 reset mid-handler with EXL=1, EPC=0x3000 -> all regs 0 asynchronously; int_req=0 before next clk.

Source files
------------

// File: rtl/cp0_pkg.sv
// CP0 register addresses, ExcCode values and SR/Cause bit positions
// shared by the coprocessor 0 RTL.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_SR       = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int unsigned SR_IE    = 0;
    localparam int unsigned SR_EXL   = 1;
    localparam int unsigned IP_LO    = 10;
    localparam int unsigned EXC_LO   = 2;
    localparam int unsigned CAUSE_TI = 30;
    localparam int unsigned CAUSE_BD = 31;

endpackage

// File: rtl/cp0_intc_timer_if.sv
// Pipeline-side bus of CP0: mfc0/mtc0 access, M-stage exception info,
// interrupt lines, and the redirect/EPC results.
interface cp0_intc_timer_if #(
    parameter int N_HWINT = 5
);
    logic [4:0]         rd_addr;
    logic [31:0]        rd_data;
    logic               we;
    logic [4:0]         wr_addr;
    logic [31:0]        wr_data;
    logic [31:0]        pc;
    logic               in_delay_slot;
    logic               exc_valid;
    logic [4:0]         exc_code;
    logic [31:0]        bad_vaddr;
    logic [N_HWINT-1:0] hwint;
    logic               eret;
    logic               int_req;
    logic [31:0]        epc;

    modport master (
        output rd_addr, we, wr_addr, wr_data, pc, in_delay_slot,
               exc_valid, exc_code, bad_vaddr, hwint, eret,
        input  rd_data, int_req, epc
    );

    modport slave (
        input  rd_addr, we, wr_addr, wr_data, pc, in_delay_slot,
               exc_valid, exc_code, bad_vaddr, hwint, eret,
        output rd_data, int_req, epc
    );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, Compare match sets TI,
// mtc0 Count replaces the increment and mtc0 Compare clears TI.
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic [31:0] count_inc;

    assign count_inc = count + 32'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            count <= count_we ? wr_data : count_inc;
            if (compare_we)
                compare <= wr_data;
            // A written Count never matches; a Compare write clears TI even on a match.
            if (compare_we)
                ti <= 1'b0;
            else if (!count_we && count_inc == compare)
                ti <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_intc_timer.sv
// Coprocessor 0 with configurable edge/level interrupt lines, Count/Compare
// timer, BadVAddr and nested-exception EPC handling.
module cp0_intc_timer
    import cp0_pkg::*;
#(
    parameter int           N_HWINT   = 5,
    parameter logic [N_HWINT-1:0] EDGE_MASK = '0,
    parameter logic [31:0]  PRID      = 32'h1737_3552
) (
    input  logic             clk,
    input  logic             reset,
    cp0_intc_timer_if.slave  bus
);

    logic [5:0]         im;
    logic               exl;
    logic               ie;
    logic               bd;
    logic [4:0]         exc_code_q;
    logic [31:0]        epc_q;
    logic [31:0]        badvaddr_q;
    logic [N_HWINT-1:0] hw_q;
    logic [N_HWINT-1:0] edge_q;
    logic [5:0]         ip;
    logic [31:0]        count;
    logic [31:0]        compare;
    logic               ti;
    logic               take;
    logic [31:0]        epc_take;
    logic               sr_we;
    logic               cause_we;
    logic               epc_we;

    assign sr_we    = bus.we && bus.wr_addr == CP0_SR;
    assign cause_we = bus.we && bus.wr_addr == CP0_CAUSE;
    assign epc_we   = bus.we && bus.wr_addr == CP0_EPC;

    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (bus.we && bus.wr_addr == CP0_COUNT),
        .compare_we (bus.we && bus.wr_addr == CP0_COMPARE),
        .wr_data    (bus.wr_data),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_comb begin
        ip = '0;
        for (int unsigned i = 0; i < N_HWINT; i++)
            ip[i] = EDGE_MASK[i] ? edge_q[i] : hw_q[i];
        ip[5] = ti;
    end

    assign take        = bus.exc_valid | (ie & ~exl & |(ip & im));
    assign bus.int_req = take;
    assign bus.epc     = epc_q;
    assign epc_take    = (bus.pc & 32'hFFFF_FFFC) - (bus.in_delay_slot ? 32'd4 : 32'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hw_q   <= '0;
            edge_q <= '0;
        end else begin
            hw_q <= bus.hwint;
            // New edge wins over a same-cycle clearing Cause write.
            for (int unsigned i = 0; i < N_HWINT; i++) begin
                if (EDGE_MASK[i]) begin
                    if (bus.hwint[i] && !hw_q[i])
                        edge_q[i] <= 1'b1;
                    else if (cause_we && !bus.wr_data[IP_LO + i])
                        edge_q[i] <= 1'b0;
                end
            end
        end
    end

    // Later assignments override earlier ones: mtc0, then eret, then a take.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im         <= '0;
            exl        <= 1'b0;
            ie         <= 1'b0;
            bd         <= 1'b0;
            exc_code_q <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            if (sr_we) begin
                im  <= bus.wr_data[15:10];
                exl <= bus.wr_data[SR_EXL];
                ie  <= bus.wr_data[SR_IE];
            end
            if (epc_we)
                epc_q <= bus.wr_data & 32'hFFFF_FFFC;
            if (bus.eret)
                exl <= 1'b0;
            if (take) begin
                exl        <= 1'b1;
                exc_code_q <= bus.exc_valid ? bus.exc_code : EXC_INT;
                if (!exl) begin
                    bd    <= bus.in_delay_slot;
                    epc_q <= epc_take;
                end
                if (bus.exc_valid && (bus.exc_code == EXC_ADEL || bus.exc_code == EXC_ADES))
                    badvaddr_q <= bus.bad_vaddr;
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        case (bus.rd_addr)
            CP0_BADVADDR: bus.rd_data = badvaddr_q;
            CP0_COUNT:    bus.rd_data = count;
            CP0_COMPARE:  bus.rd_data = compare;
            CP0_SR:       bus.rd_data = {16'b0, im, 8'b0, exl, ie};
            CP0_CAUSE:    bus.rd_data = {bd, ti, 14'b0, ip, 3'b0, exc_code_q, 2'b0};
            CP0_EPC:      bus.rd_data = epc_q;
            CP0_PRID:     bus.rd_data = PRID;
            default:      bus.rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_intc_timer.sv
// Directed bench for cp0_intc_timer: line 0 level, line 1 edge-latched.
module tb_cp0_intc_timer;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [31:0] d;

    cp0_intc_timer_if #(.N_HWINT(5)) bus ();

    cp0_intc_timer #(
        .N_HWINT   (5),
        .EDGE_MASK (5'b00010),
        .PRID      (32'h1737_3552)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        bus.rd_addr = a;
        #1;
        v = bus.rd_data;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        bus.we      = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = v;
        tick();
        bus.we      = 1'b0;
    endtask

    initial begin
        n_tests           = 0;
        n_fail            = 0;
        reset             = 1'b1;
        bus.rd_addr       = '0;
        bus.we            = 1'b0;
        bus.wr_addr       = '0;
        bus.wr_data       = '0;
        bus.pc            = '0;
        bus.in_delay_slot = 1'b0;
        bus.exc_valid     = 1'b0;
        bus.exc_code      = '0;
        bus.bad_vaddr     = '0;
        bus.hwint         = '0;
        bus.eret          = 1'b0;

        repeat (2) tick();
        reset = 1'b0;
        rd(5'd9,  d); check("rst_count", d, 32'h0);
        rd(5'd12, d); check("rst_sr", d, 32'h0);
        rd(5'd13, d); check("rst_cause", d, 32'h0);
        rd(5'd15, d); check("rst_prid", d, 32'h1737_3552);
        rd(5'd10, d); check("unmapped", d, 32'h0);
        check("rst_epc", bus.epc, 32'h0);
        check("rst_int_req", {31'b0, bus.int_req}, 32'h0);

        // 1: level interrupt on line 0
        wr(5'd12, 32'h0000_0401);
        bus.pc    = 32'h0000_1000;
        bus.hwint = 5'b00001;
        tick();
        check("t1_int_req", {31'b0, bus.int_req}, 32'h1);
        bus.hwint = '0;
        tick();
        check("t1_epc", bus.epc, 32'h0000_1000);
        rd(5'd12, d); check("t1_sr_exl", d, 32'h0000_0403);
        rd(5'd13, d); check("t1_cause", d, 32'h0);
        check("t1_int_req_off", {31'b0, bus.int_req}, 32'h0);

        // 2: AdEL in delay slot
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        bus.exc_valid     = 1'b1;
        bus.exc_code      = 5'd4;
        bus.bad_vaddr     = 32'h0000_3001;
        bus.in_delay_slot = 1'b1;
        bus.pc            = 32'h0000_3008;
        #1;
        check("t2_int_req", {31'b0, bus.int_req}, 32'h1);
        tick();
        bus.exc_valid     = 1'b0;
        bus.in_delay_slot = 1'b0;
        check("t2_epc", bus.epc, 32'h0000_3004);
        rd(5'd13, d); check("t2_cause", d, 32'h8000_0010);
        rd(5'd8,  d); check("t2_badvaddr", d, 32'h0000_3001);

        // 3: nested exception keeps EPC/BD, then eret
        bus.exc_valid = 1'b1;
        bus.exc_code  = 5'd10;
        bus.pc        = 32'h0000_5000;
        tick();
        bus.exc_valid = 1'b0;
        check("t3_epc_held", bus.epc, 32'h0000_3004);
        rd(5'd13, d); check("t3_cause", d, 32'h8000_0028);
        rd(5'd8,  d); check("t3_badvaddr_held", d, 32'h0000_3001);
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        rd(5'd12, d); check("t3_sr_eret", d, 32'h0000_0401);

        // 4: edge line 1 latches a 1-cycle pulse with IE=0
        wr(5'd12, 32'h0000_0800);
        bus.hwint = 5'b00010;
        tick();
        bus.hwint = '0;
        tick();
        tick();
        rd(5'd13, d); check("t4_ip_latched", d & 32'h0000_FC00, 32'h0000_0800);
        check("t4_no_int", {31'b0, bus.int_req}, 32'h0);
        wr(5'd13, 32'h0000_0800);
        rd(5'd13, d); check("t4_ip_kept", d & 32'h0000_FC00, 32'h0000_0800);
        wr(5'd13, 32'h0);
        rd(5'd13, d); check("t4_ip_cleared", d & 32'h0000_FC00, 32'h0);

        // 5: Count wrap matches Compare=0
        wr(5'd11, 32'h0);
        wr(5'd9, 32'hFFFF_FFFE);
        rd(5'd9,  d); check("t5_count_wr", d, 32'hFFFF_FFFE);
        rd(5'd13, d); check("t5_ti0", d & 32'h4000_8000, 32'h0);
        tick();
        rd(5'd13, d); check("t5_ti1", d & 32'h4000_8000, 32'h0);
        tick();
        rd(5'd9,  d); check("t5_count_wrap", d, 32'h0);
        rd(5'd13, d); check("t5_ti_set", d & 32'h4000_8000, 32'h4000_8000);
        wr(5'd11, 32'h0000_0100);
        rd(5'd13, d); check("t5_ti_clr", d & 32'h4000_8000, 32'h0);
        rd(5'd11, d); check("t5_compare", d, 32'h0000_0100);
        rd(5'd9,  d); check("t5_count_inc", d, 32'h1);

        // 6: asynchronous reset mid-handler; line 1 held high through reset
        wr(5'd14, 32'h0000_3003);
        wr(5'd12, 32'h0000_0402);
        check("t6_epc_pre", bus.epc, 32'h0000_3000);
        bus.hwint = 5'b00010;
        reset = 1'b1;
        #1;
        check("t6_epc_rst", bus.epc, 32'h0);
        check("t6_int_req_rst", {31'b0, bus.int_req}, 32'h0);
        rd(5'd12, d); check("t6_sr_rst", d, 32'h0);
        rd(5'd13, d); check("t6_cause_rst", d, 32'h0);
        rd(5'd11, d); check("t6_compare_rst", d, 32'h0);
        rd(5'd8,  d); check("t6_badvaddr_rst", d, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        rd(5'd13, d); check("t6_edge_after_rst", d & 32'h0000_FC00, 32'h0000_0800);
        bus.hwint = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
